// File: rtl/adc_scan_sequencer.sv
// Round-robin ADC channel scanner: issues one command per channel, waits for the matching
// response (with timeout) and publishes it. Define ADC_SCAN_AVG4_EN to average 4 conversions.
module adc_scan_sequencer #(
  parameter int CH_FIRST    = 1,
  parameter int NUM_CH      = 8,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic        clock_clk,
  input  logic        reset_sink_reset,
  input  logic        scan_en,
  output logic        command_valid,
  output logic [4:0]  command_channel,
  output logic        command_startofpacket,
  output logic        command_endofpacket,
  input  logic        command_ready,
  input  logic        response_valid,
  input  logic [4:0]  response_channel,
  input  logic [11:0] response_data,
  output logic        sample_valid,
  output logic [4:0]  sample_channel,
  output logic [11:0] sample_data,
  output logic        busy,
  output logic        err_timeout,
  output logic        err_channel
);

  typedef enum logic [1:0] {IDLE, CMD, WAIT, OUT} state_t;

  localparam logic [4:0]  CH_LO   = 5'(CH_FIRST);
  localparam logic [4:0]  CH_HI   = 5'(CH_FIRST + NUM_CH - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [4:0]  cur_ch_q, cur_ch_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  smp_ch_q, smp_ch_d;
  logic [11:0] smp_data_q, smp_data_d;
  logic        err_to_q, err_to_d;
  logic        err_ch_q, err_ch_d;
  logic        resp_match;
`ifdef ADC_SCAN_AVG4_EN
  logic [13:0] acc_q, acc_d;
  logic [1:0]  rep_q, rep_d;
  logic [13:0] sum;
`endif

  function automatic logic [4:0] next_ch(input logic [4:0] ch);
    return (ch == CH_HI) ? CH_LO : ch + 5'd1;
  endfunction

  assign resp_match = response_valid && (response_channel == cur_ch_q);

  always_comb begin
    state_d    = state_q;
    cur_ch_d   = cur_ch_q;
    cnt_d      = cnt_q;
    smp_ch_d   = smp_ch_q;
    smp_data_d = smp_data_q;
    err_to_d   = err_to_q;
    err_ch_d   = err_ch_q;
`ifdef ADC_SCAN_AVG4_EN
    acc_d      = acc_q;
    rep_d      = rep_q;
    sum        = acc_q + {2'b00, response_data};
`endif
    case (state_q)
      IDLE: if (scan_en) state_d = CMD;
      CMD: begin
        if (command_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // A matching response always beats the timeout, even on the last cycle.
        if (resp_match) begin
`ifdef ADC_SCAN_AVG4_EN
          if (rep_q == 2'd3) begin
            smp_ch_d   = cur_ch_q;
            smp_data_d = sum[13:2];
            acc_d      = '0;
            rep_d      = '0;
            state_d    = OUT;
          end else begin
            acc_d   = sum;
            rep_d   = rep_q + 2'd1;
            state_d = CMD;
          end
`else
          smp_ch_d   = cur_ch_q;
          smp_data_d = response_data;
          state_d    = OUT;
`endif
        end else begin
          if (response_valid) err_ch_d = 1'b1;
          if (cnt_q == TO_LAST) begin
            err_to_d = 1'b1;
            cur_ch_d = next_ch(cur_ch_q);
            state_d  = IDLE;
`ifdef ADC_SCAN_AVG4_EN
            acc_d    = '0;
            rep_d    = '0;
`endif
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      OUT: begin
        cur_ch_d = next_ch(cur_ch_q);
        state_d  = scan_en ? CMD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_clk) begin
    if (reset_sink_reset) begin
      state_q    <= IDLE;
      cur_ch_q   <= CH_LO;
      cnt_q      <= '0;
      smp_ch_q   <= '0;
      smp_data_q <= '0;
      err_to_q   <= 1'b0;
      err_ch_q   <= 1'b0;
`ifdef ADC_SCAN_AVG4_EN
      acc_q      <= '0;
      rep_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cur_ch_q   <= cur_ch_d;
      cnt_q      <= cnt_d;
      smp_ch_q   <= smp_ch_d;
      smp_data_q <= smp_data_d;
      err_to_q   <= err_to_d;
      err_ch_q   <= err_ch_d;
`ifdef ADC_SCAN_AVG4_EN
      acc_q      <= acc_d;
      rep_q      <= rep_d;
`endif
    end
  end

  assign command_valid         = (state_q == CMD);
  assign command_startofpacket = (state_q == CMD);
  assign command_endofpacket   = (state_q == CMD);
  assign command_channel       = (state_q == CMD) ? cur_ch_q : 5'd0;
  assign sample_valid          = (state_q == OUT);
  assign sample_channel        = smp_ch_q;
  assign sample_data           = smp_data_q;
  assign busy                  = (state_q != IDLE);
  assign err_timeout           = err_to_q;
  assign err_channel           = err_ch_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer (CH_FIRST=1, NUM_CH=3, TIMEOUT_CYC=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_adc_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_en;
  logic        command_valid;
  logic [4:0]  command_channel;
  logic        command_startofpacket;
  logic        command_endofpacket;
  logic        command_ready;
  logic        response_valid;
  logic [4:0]  response_channel;
  logic [11:0] response_data;
  logic        sample_valid;
  logic [4:0]  sample_channel;
  logic [11:0] sample_data;
  logic        busy;
  logic        err_timeout;
  logic        err_channel;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  adc_scan_sequencer #(.CH_FIRST(1), .NUM_CH(3), .TIMEOUT_CYC(16)) dut (
    .clock_clk            (clk),
    .reset_sink_reset     (rst),
    .scan_en              (scan_en),
    .command_valid        (command_valid),
    .command_channel      (command_channel),
    .command_startofpacket(command_startofpacket),
    .command_endofpacket  (command_endofpacket),
    .command_ready        (command_ready),
    .response_valid       (response_valid),
    .response_channel     (response_channel),
    .response_data        (response_data),
    .sample_valid         (sample_valid),
    .sample_channel       (sample_channel),
    .sample_data          (sample_data),
    .busy                 (busy),
    .err_timeout          (err_timeout),
    .err_channel          (err_channel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for a command on channel ch, hold it off for 'stall' cycles, then accept it.
  // Returns on the first WAIT cycle.
  task automatic wait_cmd(input logic [4:0] ch, input int stall);
    int n = 0;
    while (!command_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_seen", command_valid, 1);
    chk("cmd_channel", command_channel, ch);
    chk("cmd_sop_eop", {command_startofpacket, command_endofpacket}, 2'b11);
    command_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("cmd_stable", {command_valid, command_channel, command_startofpacket, command_endofpacket},
          {1'b1, ch, 2'b11});
    end
    command_ready = 1'b1;
    @(negedge clk);
    command_ready = 1'b0;
    chk("cmd_accept_drop", {command_valid, command_startofpacket, command_endofpacket}, 3'b000);
    chk("busy_wait", busy, 1);
  endtask

  // Drive a response dly cycles after accept; check the resulting strobe on the next cycle.
  task automatic respond(input logic [4:0] ch, input logic [11:0] d, input int dly,
                         input logic exp_sv, input logic [11:0] exp_d);
    repeat (dly - 1) @(negedge clk);
    response_valid   = 1'b1;
    response_channel = ch;
    response_data    = d;
    chk("pre_sample", sample_valid, 0);
    @(negedge clk);
    response_valid = 1'b0;
    response_data  = '0;
    chk("sample_valid", sample_valid, exp_sv);
    if (exp_sv) begin
      chk("sample_channel", sample_channel, ch);
      chk("sample_data", sample_data, exp_d);
      @(negedge clk);
      chk("strobe_one_cycle", sample_valid, 0);
      chk("sample_hold", {sample_channel, sample_data}, {ch, exp_d});
    end
  endtask

  initial begin
    rst = 1'b1; scan_en = 1'b0; command_ready = 1'b0;
    response_valid = 1'b0; response_channel = '0; response_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_cmd", {command_valid, command_channel, command_startofpacket, command_endofpacket}, 0);
    chk("rst_sample", {sample_valid, sample_channel, sample_data}, 0);
    chk("rst_flags", {busy, err_timeout, err_channel}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    scan_en = 1'b1;
    @(negedge clk);

`ifdef ADC_SCAN_AVG4_EN
    begin
      logic [11:0] vals [4];
      vals[0] = 12'h001; vals[1] = 12'h002; vals[2] = 12'h003; vals[3] = 12'hFFF;
      for (int k = 0; k < 4; k++) begin
        wait_cmd(5'd1, 0);
        respond(5'd1, vals[k], 2, (k == 3), 12'h401);
      end
      wait_cmd(5'd2, 0);
    end
`else
    // Continuous scan with wrap-around
    wait_cmd(5'd1, 0); respond(5'd1, 12'h101, 5, 1'b1, 12'h101);
    wait_cmd(5'd2, 0); respond(5'd2, 12'h102, 5, 1'b1, 12'h102);
    wait_cmd(5'd3, 0); respond(5'd3, 12'h103, 5, 1'b1, 12'h103);
    wait_cmd(5'd1, 0); respond(5'd1, 12'h101, 5, 1'b1, 12'h101);

    // Backpressure on the command
    wait_cmd(5'd2, 7); respond(5'd2, 12'h222, 3, 1'b1, 12'h222);

    // Wrong-channel response is flagged and discarded
    wait_cmd(5'd3, 0);
    response_valid = 1'b1; response_channel = 5'd5; response_data = 12'h555;
    @(negedge clk);
    response_valid = 1'b0;
    chk("err_channel_set", err_channel, 1);
    chk("wrong_ch_no_sample", {sample_valid, busy}, 2'b01);
    respond(5'd3, 12'hABC, 1, 1'b1, 12'hABC);

    // Response on the final timeout cycle wins
    wait_cmd(5'd1, 0); respond(5'd1, 12'h0F1, 16, 1'b1, 12'h0F1);
    chk("late_resp_no_timeout", err_timeout, 0);

    // scan_en dropped during WAIT: finish, then IDLE
    wait_cmd(5'd2, 0);
    scan_en = 1'b0;
    respond(5'd2, 12'h0AA, 4, 1'b1, 12'h0AA);
    chk("scan_off_idle", {busy, command_valid}, 2'b00);
    repeat (3) @(negedge clk);
    chk("scan_off_stays_idle", {busy, command_valid}, 2'b00);

    // Timeout after 16 WAIT cycles, next command on next channel
    scan_en = 1'b1;
    @(negedge clk);
    wait_cmd(5'd3, 0);
    chk("to_not_yet_c1", err_timeout, 0);
    repeat (15) @(negedge clk);
    chk("to_not_yet_c16", {err_timeout, busy}, 2'b01);
    @(negedge clk);
    chk("to_set", err_timeout, 1);
    chk("to_idle_no_sample", {busy, sample_valid}, 2'b00);
    chk("to_sample_hold", {sample_channel, sample_data}, {5'd2, 12'h0AA});
    chk("err_channel_sticky", err_channel, 1);
    wait_cmd(5'd1, 0);

    // Reset in WAIT clears everything; a late response is ignored
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wait_cmd", {command_valid, command_channel, busy}, 0);
    chk("rst_wait_flags", {err_timeout, err_channel}, 0);
    chk("rst_wait_sample", {sample_valid, sample_channel, sample_data}, 0);
    rst = 1'b0; scan_en = 1'b0;
    response_valid = 1'b1; response_channel = 5'd1; response_data = 12'h777;
    @(negedge clk);
    response_valid = 1'b0;
    chk("late_resp_ignored", {err_channel, sample_valid, busy}, 0);
    chk("late_resp_no_data", sample_data, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
